// File: rtl/rah_sha_host_adapter.sv
// Host-side adapter: serializes a SHA message into RAH FIFO packets and
// reassembles the returned hash from RAH words, dropping stalled partial hashes.
module rah_sha_host_adapter #(
    parameter int SHA_INPUT_WIDTH  = 512,
    parameter int SHA_OUTPUT_WIDTH = 256,
    parameter int RAH_PACKET_WIDTH = 48,
    parameter int RX_TIMEOUT       = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        msg_valid,
    input  logic [SHA_INPUT_WIDTH-1:0]  msg_data,
    output logic                        msg_ready,
    input  logic                        tx_fifo_full,
    output logic                        tx_fifo_wr_en,
    output logic [RAH_PACKET_WIDTH-1:0] tx_fifo_wr_data,
    input  logic                        rx_valid,
    input  logic [RAH_PACKET_WIDTH-1:0] rx_data,
    output logic [SHA_OUTPUT_WIDTH-1:0] hash_out,
    output logic                        hash_valid,
    output logic                        err_timeout,
    output logic                        tx_busy,
    output logic                        dbg_tx_state
);

    localparam int PW        = RAH_PACKET_WIDTH;
    localparam int NUM_PKTS  = (SHA_INPUT_WIDTH + PW - 1) / PW;
    localparam int NUM_WORDS = (SHA_OUTPUT_WIDTH + PW - 1) / PW;
    localparam int SHIFT_W   = (NUM_WORDS - 1) * PW;
    localparam int TAIL_W    = SHA_OUTPUT_WIDTH - SHIFT_W;
    localparam int IDLE_W    = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;

    localparam logic [3:0]        LAST_PKT  = 4'(NUM_PKTS - 1);
    localparam logic [2:0]        LAST_WORD = 3'(NUM_WORDS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

    typedef enum logic {TX_IDLE = 1'b0, TX_SEND = 1'b1} tx_state_t;

    tx_state_t                  tx_state;
    logic [3:0]                 pkt_idx;
    logic [SHA_INPUT_WIDTH-1:0] msg_sh;

    logic [2:0]                 rx_cnt;
    logic [SHIFT_W-1:0]         rx_shift;
    logic [IDLE_W-1:0]          idle_cnt;

    // Handshakes: a message moves on a rising edge with msg_valid && msg_ready;
    // a packet moves on a rising edge with tx_fifo_wr_en (never while tx_fifo_full);
    // an RX word moves on every rising edge with rx_valid (no backpressure).
    assign tx_fifo_wr_en   = (tx_state == TX_SEND) && !tx_fifo_full && !rst;
    assign tx_fifo_wr_data = msg_sh[SHA_INPUT_WIDTH-1 -: PW];
    assign dbg_tx_state    = tx_state;

    // The message is shifted up one packet per write, so the head is always the
    // next packet; zeros shifted in form the padding of the final short packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            pkt_idx   <= '0;
            msg_sh    <= '0;
            msg_ready <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (msg_valid) begin
                        msg_sh    <= msg_data;
                        pkt_idx   <= '0;
                        tx_state  <= TX_SEND;
                        msg_ready <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                TX_SEND: begin
                    if (!tx_fifo_full) begin
                        msg_sh <= msg_sh << PW;
                        if (pkt_idx == LAST_PKT) begin
                            pkt_idx   <= '0;
                            tx_state  <= TX_IDLE;
                            msg_ready <= 1'b1;
                            tx_busy   <= 1'b0;
                        end else begin
                            pkt_idx <= pkt_idx + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    // The idle counter only runs while a partial hash is held, and an arriving
    // word takes priority over an expiring timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt      <= '0;
            rx_shift    <= '0;
            idle_cnt    <= '0;
            hash_out    <= '0;
            hash_valid  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            hash_valid  <= 1'b0;
            err_timeout <= 1'b0;
            if (rx_valid) begin
                idle_cnt <= '0;
                if (rx_cnt == LAST_WORD) begin
                    hash_out   <= {rx_shift, rx_data[PW-1 -: TAIL_W]};
                    hash_valid <= 1'b1;
                    rx_cnt     <= '0;
                end else begin
                    rx_shift <= {rx_shift[SHIFT_W-PW-1:0], rx_data};
                    rx_cnt   <= rx_cnt + 3'd1;
                end
            end else if (rx_cnt != 3'd0) begin
                if (idle_cnt == IDLE_LAST) begin
                    rx_cnt      <= '0;
                    idle_cnt    <= '0;
                    err_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
